// File: rtl/ni_rx.sv
// ni_rx: NI receive path; router flits buffered in a FIFO and popped by the core as {addr,data} halves.
//   Ports: clk, reset (sync, active-high); net_flit/net_valid/net_ready (router side);
//   core_read_en/core_read_data/core_read_addr/core_read_valid/core_read_empty (core side);
//   rx_count (occupancy), drop_count (address-filter drops).
//   Macro NI_RX_ADDR_FILTER_EN enables discarding flits whose addr differs from NODE_ADDR.
module ni_rx #(
  parameter int ADDRSIZE = 5,
  parameter int MSB_SLOT = 5,
  localparam int DSIZE = 1 << MSB_SLOT,
  localparam int RSIZE = 1 << (MSB_SLOT - 1),
  localparam int DEPTH = 1 << ADDRSIZE,
  parameter logic [RSIZE-1:0] NODE_ADDR = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DSIZE-1:0]    net_flit,
  input  logic                net_valid,
  output logic                net_ready,
  input  logic                core_read_en,
  output logic [RSIZE-1:0]    core_read_data,
  output logic [RSIZE-1:0]    core_read_addr,
  output logic                core_read_valid,
  output logic                core_read_empty,
  output logic [ADDRSIZE:0]   rx_count,
  output logic [RSIZE-1:0]    drop_count
);
  logic [DSIZE-1:0]    mem [DEPTH];
  logic [ADDRSIZE-1:0] wr_ptr, rd_ptr;
  logic                push, keep, pop;
  assign net_ready       = rx_count != (ADDRSIZE+1)'(DEPTH);
  assign core_read_empty = rx_count == '0;
  assign push            = net_valid && net_ready;
  assign pop             = core_read_en && !core_read_empty;
`ifdef NI_RX_ADDR_FILTER_EN
  assign keep = push && net_flit[DSIZE-1:RSIZE] == NODE_ADDR;
  always_ff @(posedge clk) begin
    if (reset) drop_count <= '0;
    else if (push && !keep && drop_count != '1) drop_count <= drop_count + RSIZE'(1);
  end
`else
  logic unused_node;
  assign unused_node = ^NODE_ADDR;
  assign keep        = push;
  assign drop_count  = '0;
`endif
  always_ff @(posedge clk) begin
    if (keep) mem[wr_ptr] <= net_flit;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      rx_count        <= '0;
      core_read_data  <= '0;
      core_read_addr  <= '0;
      core_read_valid <= 1'b0;
    end else begin
      if (keep) wr_ptr <= wr_ptr + ADDRSIZE'(1);
      if (pop) begin
        rd_ptr         <= rd_ptr + ADDRSIZE'(1);
        core_read_addr <= mem[rd_ptr][DSIZE-1:RSIZE];
        core_read_data <= mem[rd_ptr][RSIZE-1:0];
      end
      core_read_valid <= pop;
      rx_count        <= rx_count + (ADDRSIZE+1)'(keep) - (ADDRSIZE+1)'(pop);
    end
  end
endmodule

// File: tb/tb_ni_rx.sv
// tb_ni_rx: table-driven and scoreboard-checked bench for ni_rx.
module tb_ni_rx;
`ifdef NI_RX_ADDR_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] net_flit = '0;
  logic        net_valid = 1'b0;
  logic        net_ready;
  logic        core_read_en = 1'b0;
  logic [15:0] core_read_data, core_read_addr, drop_count;
  logic        core_read_valid, core_read_empty;
  logic [5:0]  rx_count;
  int          vectors = 0;
  int          errs = 0;
  logic [31:0] mq[$];
  logic [31:0] sb[$];
  logic [31:0] last = '0;
  logic [15:0] mdrop = '0;
  typedef struct {
    logic [31:0] flit;
    bit          v;
    bit          r;
    int          exp_cnt;
    bit          exp_valid;
  } vec_t;
  vec_t tbl[9];

  ni_rx #(.ADDRSIZE(5), .MSB_SLOT(5), .NODE_ADDR(16'h0003)) dut (
    .clk(clk), .reset(reset), .net_flit(net_flit), .net_valid(net_valid), .net_ready(net_ready),
    .core_read_en(core_read_en), .core_read_data(core_read_data), .core_read_addr(core_read_addr),
    .core_read_valid(core_read_valid), .core_read_empty(core_read_empty),
    .rx_count(rx_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    net_valid = 1'b0;
    core_read_en = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
    mq.delete();
    sb.delete();
    last = '0;
    mdrop = '0;
    chk("rst_count", rx_count, 0);
    chk("rst_empty", core_read_empty, 1);
    chk("rst_ready", net_ready, 1);
    chk("rst_valid", core_read_valid, 0);
    chk("rst_addr", core_read_addr, 0);
    chk("rst_data", core_read_data, 0);
    chk("rst_drop", drop_count, 0);
  endtask

  task automatic step(input logic [31:0] f, input bit v, input bit r);
    bit eh, ek, ep;
    eh = v && (mq.size() != 32);
    ek = eh && (!FILT || f[31:16] == 16'h0003);
    ep = r && (mq.size() != 0);
    net_flit = f;
    net_valid = v;
    core_read_en = r;
    @(posedge clk);
    if (ep) sb.push_back(mq.pop_front());
    if (ek) mq.push_back(f);
    if (eh && !ek && mdrop != 16'hffff) mdrop++;
    #1;
    net_valid = 1'b0;
    core_read_en = 1'b0;
    chk("valid", core_read_valid, ep);
    if (core_read_valid && sb.size() != 0) last = sb.pop_front();
    sb.delete();
    chk("addr", core_read_addr, last[31:16]);
    chk("data", core_read_data, last[15:0]);
    chk("count", rx_count, mq.size());
    chk("empty", core_read_empty, mq.size() == 0);
    chk("ready", net_ready, mq.size() != 32);
    chk("drop", drop_count, mdrop);
  endtask

  initial begin
    tbl[0] = '{32'h0003_1111, 1, 0, 1, 0};
    tbl[1] = '{32'h0003_2222, 1, 0, 2, 0};
    tbl[2] = '{32'h0003_3333, 1, 1, 2, 1};
    tbl[3] = '{32'h0, 0, 1, 1, 1};
    tbl[4] = '{32'h0, 0, 1, 0, 1};
    tbl[5] = '{32'h0, 0, 1, 0, 0};
    tbl[6] = '{32'h0003_4444, 1, 1, 1, 0};
    tbl[7] = '{32'h0, 0, 0, 1, 0};
    tbl[8] = '{32'h0, 0, 1, 0, 1};
    do_reset(2);
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].flit, tbl[i].v, tbl[i].r);
      chk($sformatf("tbl%0d_count", i), rx_count, tbl[i].exp_cnt);
      chk($sformatf("tbl%0d_valid", i), core_read_valid, tbl[i].exp_valid);
    end
    step(32'hA5A5_AAAA, 1, 0);
    step(32'h0, 0, 1);
`ifndef NI_RX_ADDR_FILTER_EN
    chk("t2_addr", core_read_addr, 16'hA5A5);
    chk("t2_data", core_read_data, 16'hAAAA);
`endif
    step(32'h0, 0, 0);
    chk("t2_valid_off", core_read_valid, 0);
    chk("t2_empty", core_read_empty, 1);
    for (int i = 0; i < 32; i++) step({16'(i), ~16'(i)}, 1, 0);
`ifndef NI_RX_ADDR_FILTER_EN
    chk("t3_full_ready", net_ready, 0);
    chk("t3_full_count", rx_count, 32);
`endif
    step(32'hDEAD_BEEF, 1, 0);
    step(32'hDEAD_BEEF, 1, 1);
    for (int i = 1; i < 33; i++) step(32'h0, 0, 1);
    for (int i = 0; i < 5; i++) step({16'h0003, 16'(16'h50 + i)}, 1, 0);
    for (int i = 0; i < 6; i++) step(32'h0, 0, 1);
    do_reset(1);
    for (int i = 0; i < 3; i++) step({16'h0003, 16'(i)}, 1, 0);
    for (int i = 0; i < 10; i++) begin
      step({16'h0003, 16'(16'h100 + i)}, 1, 1);
      chk("t4_count", rx_count, 3);
    end
    for (int i = 0; i < 4; i++) step(32'h0, 0, 1);
    for (int i = 0; i < 7; i++) step({16'h0003, 16'(16'h200 + i)}, 1, 0);
    chk("t5_count7", rx_count, 7);
    do_reset(1);
    step(32'h0003_0AAA, 1, 0);
    step(32'h0004_0BBB, 1, 0);
    step(32'h0003_0CCC, 1, 0);
    chk("t6_drop", drop_count, FILT ? 1 : 0);
    chk("t6_count", rx_count, FILT ? 2 : 3);
    for (int i = 0; i < 4; i++) step(32'h0, 0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
